dda_traversal: RTL and testbench

//  Consumer end of the ray-setup handshake. Accepts one ray per transfer: step signs, Q8.8 side/delta

---
 rtl/raycast_pkg.sv | 21 ++
 rtl/dda_traversal.sv | 165 ++++++++++++++++
 tb/tb_dda_traversal.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raycast_pkg.sv
// Shared types and helpers for the raycaster DDA datapath.
package raycast_pkg;

  typedef logic [15:0] q8_8_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_CHECK,
    S_OUTPUT
  } dda_state_t;

  // Distances pin at the largest Q8.8 value instead of wrapping.
  function automatic q8_8_t sat_add_q88(input q8_8_t a, input q8_8_t b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/dda_traversal.sv
// DDA grid walker: takes one ray from setup, steps through the map BRAM until a wall,
// the map border or the step limit is reached, then holds the result for the renderer.
module dda_traversal
  import raycast_pkg::*;
#(
  parameter int MAP_W       = 24,
  parameter int MAP_H       = 24,
  parameter int WALL_W      = 4,
  parameter int MAP_RD_LAT  = 2,
  parameter int MAX_STEPS   = 64,
  parameter int BORDER_TYPE = 1
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_in,
  input  logic                             valid_ray_in,
  output logic                             dda_data_ready_out,
  input  logic [8:0]                       hcount_in,
  input  logic [15:0]                      posX,
  input  logic [15:0]                      posY,
  input  logic                             stepX,
  input  logic                             stepY,
  input  logic [15:0]                      sideDistX,
  input  logic [15:0]                      sideDistY,
  input  logic [15:0]                      deltaDistX,
  input  logic [15:0]                      deltaDistY,
  output logic [$clog2(MAP_W*MAP_H)-1:0]   map_addr_out,
  input  logic [WALL_W-1:0]                map_data_in,
  input  logic                             out_ready_in,
  output logic                             valid_out,
  output logic [8:0]                       hcount_out,
  output logic [15:0]                      wall_dist_out,
  output logic                             side_out,
  output logic [WALL_W-1:0]                wall_type_out
);

  localparam int ADDR_W = $clog2(MAP_W*MAP_H);
  localparam int CNT_W  = $clog2(MAX_STEPS+1);
  localparam int WAIT_W = $clog2(MAP_RD_LAT+1);

  dda_state_t r_state, w_nextState;

  logic              r_armed;
  logic [8:0]        r_hcount;
  logic              r_stepX, r_stepY;
  q8_8_t             r_sideDistX, r_sideDistY, r_deltaDistX, r_deltaDistY;
  logic [7:0]        r_mapX, r_mapY;
  logic              r_side;
  logic [CNT_W-1:0]  r_stepCnt;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [ADDR_W-1:0] r_mapAddr;
  logic [8:0]        r_hcountOut;
  q8_8_t             r_wallDist;
  logic              r_sideOut;
  logic [WALL_W-1:0] r_wallType;

  logic              w_accept, w_stepOnX, w_oob, w_hit, w_limit, w_waitDone;
  logic [7:0]        w_nextMapX, w_nextMapY;
  logic [15:0]       w_addrFull;
  logic              w_unusedBits;

  assign w_accept   = valid_ray_in && dda_data_ready_out;
  assign w_stepOnX  = r_sideDistX < r_sideDistY;
  assign w_nextMapX = w_stepOnX ? (r_stepX ? r_mapX + 8'd1 : r_mapX - 8'd1) : r_mapX;
  assign w_nextMapY = w_stepOnX ? r_mapY : (r_stepY ? r_mapY + 8'd1 : r_mapY - 8'd1);
  assign w_addrFull = {8'd0, w_nextMapY} * 16'(MAP_W) + {8'd0, w_nextMapX};
  assign w_oob      = (r_mapX >= 8'(MAP_W)) || (r_mapY >= 8'(MAP_H));
  assign w_hit      = w_oob || (map_data_in != '0);
  assign w_limit    = r_stepCnt == CNT_W'(MAX_STEPS);
  assign w_waitDone = r_waitCnt == WAIT_W'(MAP_RD_LAT-1);
  assign w_unusedBits = ^{posX[7:0], posY[7:0], w_addrFull[15:ADDR_W]};

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_nextState = S_STEP;
      S_STEP:   w_nextState = S_WAIT;
      S_WAIT:   if (w_waitDone) w_nextState = S_CHECK;
      S_CHECK:  w_nextState = (w_hit || w_limit) ? S_OUTPUT : S_STEP;
      S_OUTPUT: if (out_ready_in) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    dda_data_ready_out = r_armed && (r_state == S_IDLE);
    valid_out          = r_state == S_OUTPUT;
    map_addr_out       = r_mapAddr;
    hcount_out         = r_hcountOut;
    wall_dist_out      = r_wallDist;
    side_out           = r_sideOut;
    wall_type_out      = r_wallType;
  end

  // The result registers are only written on the way into OUTPUT, so they stay stable under backpressure.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hcount     <= '0;
      r_stepX      <= 1'b0;
      r_stepY      <= 1'b0;
      r_sideDistX  <= '0;
      r_sideDistY  <= '0;
      r_deltaDistX <= '0;
      r_deltaDistY <= '0;
      r_mapX       <= '0;
      r_mapY       <= '0;
      r_side       <= 1'b0;
      r_stepCnt    <= '0;
      r_waitCnt    <= '0;
      r_mapAddr    <= '0;
      r_hcountOut  <= '0;
      r_wallDist   <= '0;
      r_sideOut    <= 1'b0;
      r_wallType   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_hcount     <= hcount_in;
          r_stepX      <= stepX;
          r_stepY      <= stepY;
          r_sideDistX  <= sideDistX;
          r_sideDistY  <= sideDistY;
          r_deltaDistX <= deltaDistX;
          r_deltaDistY <= deltaDistY;
          r_mapX       <= posX[15:8];
          r_mapY       <= posY[15:8];
          r_stepCnt    <= '0;
        end
        S_STEP: begin
          if (w_stepOnX) r_sideDistX <= sat_add_q88(r_sideDistX, r_deltaDistX);
          else           r_sideDistY <= sat_add_q88(r_sideDistY, r_deltaDistY);
          r_side    <= !w_stepOnX;
          r_mapX    <= w_nextMapX;
          r_mapY    <= w_nextMapY;
          r_stepCnt <= r_stepCnt + CNT_W'(1);
          r_mapAddr <= w_addrFull[ADDR_W-1:0];
          r_waitCnt <= '0;
        end
        S_WAIT: r_waitCnt <= r_waitCnt + WAIT_W'(1);
        S_CHECK: if (w_hit) begin
          r_hcountOut <= r_hcount;
          r_wallDist  <= r_side ? r_sideDistY - r_deltaDistY : r_sideDistX - r_deltaDistX;
          r_sideOut   <= r_side;
          r_wallType  <= w_oob ? WALL_W'(BORDER_TYPE) : map_data_in;
        end else if (w_limit) begin
          r_hcountOut <= r_hcount;
          r_wallDist  <= 16'hFFFF;
          r_sideOut   <= r_side;
          r_wallType  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dda_traversal.sv
// Directed bench for dda_traversal with a behavioural two-cycle map BRAM.
module tb_dda_traversal;

  localparam int MAP_W = 24;
  localparam int MAP_H = 24;
  localparam int WALL_W = 4;
  localparam int LAT = 2;
  localparam int MAXS = 4;
  localparam int BORDER = 1;

  logic        clk, rstN, validRay, readyOut, stepXIn, stepYIn, outReady, validOut, sideOut;
  logic [8:0]  hcountIn, hcountOut;
  logic [15:0] posXIn, posYIn, sideXIn, sideYIn, deltaXIn, deltaYIn, wallDist;
  logic [9:0]  mapAddr;
  logic [3:0]  mapData, wallType, bramS1, bramS2;
  logic [3:0]  mapMem [0:1023];

  int checks = 0;
  int failures = 0;

  dda_traversal #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .WALL_W(WALL_W), .MAP_RD_LAT(LAT),
    .MAX_STEPS(MAXS), .BORDER_TYPE(BORDER)
  ) dut (
    .pixel_clk_in(clk), .rst_in(rstN), .valid_ray_in(validRay), .dda_data_ready_out(readyOut),
    .hcount_in(hcountIn), .posX(posXIn), .posY(posYIn), .stepX(stepXIn), .stepY(stepYIn),
    .sideDistX(sideXIn), .sideDistY(sideYIn), .deltaDistX(deltaXIn), .deltaDistY(deltaYIn),
    .map_addr_out(mapAddr), .map_data_in(mapData), .out_ready_in(outReady),
    .valid_out(validOut), .hcount_out(hcountOut), .wall_dist_out(wallDist),
    .side_out(sideOut), .wall_type_out(wallType)
  );

  always #5 clk = ~clk;

  // Map BRAM model: data appears LAT cycles after the address is presented.
  always @(posedge clk) begin
    bramS1 <= mapMem[mapAddr];
    bramS2 <= bramS1;
  end
  assign mapData = bramS2;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task clearMap;
    for (int i = 0; i < 1024; i++) mapMem[i] = 4'd0;
  endtask

  task setCell(input int x, input int y, input logic [3:0] t);
    mapMem[y*MAP_W + x] = t;
  endtask

  task setRay(input logic [8:0] hc, input logic [15:0] px, input logic [15:0] py,
              input logic sx, input logic sy, input logic [15:0] sdx, input logic [15:0] sdy,
              input logic [15:0] ddx, input logic [15:0] ddy);
    hcountIn = hc; posXIn = px; posYIn = py; stepXIn = sx; stepYIn = sy;
    sideXIn = sdx; sideYIn = sdy; deltaXIn = ddx; deltaYIn = ddy;
  endtask

  // Called and returns #1 after a rising edge; returns right after the transfer edge.
  task sendRay(output bit accepted);
    accepted = 1'b0;
    validRay = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (readyOut) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (accepted) begin
      @(posedge clk); #1;
    end
    validRay = 1'b0;
  endtask

  task waitValid(input int limit, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (cycles < limit) begin
      if (validOut) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task test_reset;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({readyOut, validOut, hcountOut, wallDist, sideOut, wallType, mapAddr} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b hc=%h dist=%h side=%b type=%h addr=%h, expected all zero",
               readyOut, validOut, hcountOut, wallDist, sideOut, wallType, mapAddr);
    end
    rstN = 1'b1;
    #1;
    checks++;
    if (readyOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready_before_edge: got %b expected 0", readyOut);
    end
    @(posedge clk); #1;
    checks++;
    if (readyOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready_after_edge: got %b expected 1", readyOut);
    end
  endtask

  // Three X steps from (2,2) to the wall at (5,2): sideX 0x80 -> 0x380, distance 0x380-0x100.
  task test_x_walk(input string tag);
    bit acc, seen;
    int cyc;
    clearMap();
    setCell(5, 2, 4'd3);
    outReady = 1'b1;
    setRay(9'd100, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0080, 16'h7F00, 16'h0100, 16'h7F00);
    sendRay(acc);
    checks++;
    if (!acc || readyOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_accept: accepted=%b ready after transfer=%b, expected 1 and 0", tag, acc, readyOut);
    end
    waitValid(200, seen, cyc);
    checks++;
    if (!seen || cyc != 12) begin
      failures++;
      $display("[TB] FAIL %s_latency: seen=%b cycles=%0d, expected valid after 12 cycles", tag, seen, cyc);
    end
    checks++;
    if ({hcountOut, wallDist, sideOut, wallType} !== {9'd100, 16'h0280, 1'b0, 4'd3}) begin
      failures++;
      $display("[TB] FAIL %s_result: got hc=%0d dist=%h side=%b type=%0d, expected hc=100 dist=0280 side=0 type=3",
               tag, hcountOut, wallDist, sideOut, wallType);
    end
    @(posedge clk); #1;
    checks++;
    if (validOut !== 1'b0 || readyOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_return_idle: got valid=%b ready=%b, expected 0 and 1", tag, validOut, readyOut);
    end
  endtask

  // Equal side distances step Y; a decoy wall on the X neighbour catches a wrong tie-break.
  task test_tie_y;
    bit acc, seen;
    int cyc;
    clearMap();
    setCell(2, 3, 4'd5);
    setCell(3, 2, 4'd7);
    outReady = 1'b1;
    setRay(9'd77, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    sendRay(acc);
    waitValid(200, seen, cyc);
    checks++;
    if (!acc || !seen || cyc != 4) begin
      failures++;
      $display("[TB] FAIL tie_latency: accepted=%b seen=%b cycles=%0d, expected 1 1 4", acc, seen, cyc);
    end
    checks++;
    if ({hcountOut, wallDist, sideOut, wallType} !== {9'd77, 16'h0100, 1'b1, 4'd5}) begin
      failures++;
      $display("[TB] FAIL tie_result: got hc=%0d dist=%h side=%b type=%0d, expected hc=77 dist=0100 side=1 type=5",
               hcountOut, wallDist, sideOut, wallType);
    end
    @(posedge clk); #1;
  endtask

  // Stepping left from column 0 wraps to 0xFF; the bounds check wins over non-zero map data.
  task test_border_wrap;
    bit acc, seen;
    int cyc;
    clearMap();
    mapMem[3*MAP_W + 255] = 4'd9;
    outReady = 1'b1;
    setRay(9'd200, 16'h0080, 16'h0380, 1'b0, 1'b1, 16'h0080, 16'h7F00, 16'h0100, 16'h7F00);
    sendRay(acc);
    waitValid(200, seen, cyc);
    checks++;
    if (!acc || !seen) begin
      failures++;
      $display("[TB] FAIL border_valid: accepted=%b seen=%b, expected 1 1", acc, seen);
    end
    checks++;
    if ({hcountOut, wallDist, sideOut, wallType} !== {9'd200, 16'h0080, 1'b0, 4'(BORDER)}) begin
      failures++;
      $display("[TB] FAIL border_result: got hc=%0d dist=%h side=%b type=%0d, expected hc=200 dist=0080 side=0 type=%0d",
               hcountOut, wallDist, sideOut, wallType, BORDER);
    end
    @(posedge clk); #1;
  endtask

  // Empty map, steps X,Y,X,Y from (10,10); the fourth step exhausts the limit.
  task test_step_limit;
    bit acc, seen;
    int cyc;
    clearMap();
    outReady = 1'b1;
    setRay(9'd311, 16'h0A80, 16'h0A80, 1'b1, 1'b0, 16'h0080, 16'h00C0, 16'h0100, 16'h0100);
    sendRay(acc);
    waitValid(200, seen, cyc);
    checks++;
    if (!acc || !seen || cyc != 16) begin
      failures++;
      $display("[TB] FAIL limit_latency: accepted=%b seen=%b cycles=%0d, expected 1 1 16", acc, seen, cyc);
    end
    checks++;
    if ({hcountOut, wallDist, sideOut, wallType} !== {9'd311, 16'hFFFF, 1'b1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL limit_result: got hc=%0d dist=%h side=%b type=%0d, expected hc=311 dist=ffff side=1 type=0",
               hcountOut, wallDist, sideOut, wallType);
    end
    @(posedge clk); #1;
  endtask

  // 0xFF00 + 0x0200 pins at 0xFFFF, so the reported distance is 0xFFFF - 0x0200.
  task test_saturation;
    bit acc, seen;
    int cyc;
    clearMap();
    setCell(6, 5, 4'd4);
    outReady = 1'b1;
    setRay(9'd42, 16'h0580, 16'h0580, 1'b1, 1'b1, 16'hFF00, 16'hFF80, 16'h0200, 16'h0100);
    sendRay(acc);
    waitValid(200, seen, cyc);
    checks++;
    if (!acc || !seen) begin
      failures++;
      $display("[TB] FAIL sat_valid: accepted=%b seen=%b, expected 1 1", acc, seen);
    end
    checks++;
    if ({hcountOut, wallDist, sideOut, wallType} !== {9'd42, 16'hFDFF, 1'b0, 4'd4}) begin
      failures++;
      $display("[TB] FAIL sat_result: got hc=%0d dist=%h side=%b type=%0d, expected hc=42 dist=fdff side=0 type=4",
               hcountOut, wallDist, sideOut, wallType);
    end
    @(posedge clk); #1;
  endtask

  task test_backpressure;
    bit acc, seen;
    int cyc;
    int bad;
    clearMap();
    setCell(2, 3, 4'd5);
    outReady = 1'b0;
    setRay(9'd77, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    sendRay(acc);
    waitValid(200, seen, cyc);
    checks++;
    if (!acc || !seen) begin
      failures++;
      $display("[TB] FAIL bp_valid: accepted=%b seen=%b, expected 1 1", acc, seen);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({validOut, readyOut, hcountOut, wallDist, sideOut, wallType} !==
          {1'b1, 1'b0, 9'd77, 16'h0100, 1'b1, 4'd5}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL bp_hold: %0d of 10 stalled cycles changed, expected 0 (last valid=%b ready=%b dist=%h)",
               bad, validOut, readyOut, wallDist);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checks++;
    if (validOut !== 1'b0 || readyOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b, expected 0 and 1", validOut, readyOut);
    end
  endtask

  task test_mid_reset;
    bit acc;
    int bad;
    clearMap();
    setCell(5, 2, 4'd3);
    outReady = 1'b1;
    setRay(9'd100, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0080, 16'h7F00, 16'h0100, 16'h7F00);
    sendRay(acc);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rstN = 1'b0;
    #1;
    checks++;
    if ({readyOut, validOut, hcountOut, wallDist, sideOut, wallType, mapAddr} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got ready=%b valid=%b hc=%h dist=%h side=%b type=%h addr=%h, expected all zero",
               readyOut, validOut, hcountOut, wallDist, sideOut, wallType, mapAddr);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (validOut !== 1'b0) bad++;
    end
    rstN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (validOut !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || readyOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_abandon: %0d cycles showed valid, ready=%b, expected 0 and 1", bad, readyOut);
    end
    test_x_walk("after_reset");
  endtask

  initial begin
    clk = 1'b0;
    rstN = 1'b0;
    validRay = 1'b0;
    outReady = 1'b0;
    setRay(9'd0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    clearMap();
    test_reset();
    test_x_walk("xwalk");
    test_tie_y();
    test_border_wrap();
    test_step_limit();
    test_saturation();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
